// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg: shared types and constants for the fetch controller     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_unit_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit_reg: write-enabled holding register, sync reset to 0    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_unit_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (we) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule : fetch_unit_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit: PC sequencing, imem req/ack and decode valid/ready     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_q,
  output logic             pc_write,
  output logic [WIDTH-1:0] pc_next,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready
);

  fetch_state_t state_q;
  logic         imem_req_q;
  logic         instr_valid_q;

  logic             redirect_take;
  logic             capture;
  logic [WIDTH-1:0] target_pc;
  logic             unused_redirect_lsbs;

  // Redirect is meaningless before the first request and outranks an ack.
  assign redirect_take = redirect && (state_q != IDLE);
  assign capture       = (state_q == REQ) && imem_ack && !redirect;
  assign target_pc     = {redirect_pc[WIDTH-1:2], 2'b00};

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pc_write = redirect_take || capture;
  assign pc_next  = redirect_take ? target_pc : (pc_q + WIDTH'(INSTR_BYTES));

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q       <= REQ;
          imem_req_q    <= 1'b1;
          instr_valid_q <= 1'b0;
        end
        REQ: begin
          if (redirect) begin
            state_q       <= REQ;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end else if (imem_ack) begin
            state_q       <= HOLD;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect || instr_ready) begin
            state_q       <= REQ;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_unit_reg #(
    .WIDTH(32)
  ) u_instr_reg (
    .clk(clk),
    .rst(rst),
    .we (capture),
    .d  (imem_rdata),
    .q  (instr)
  );

  fetch_unit_reg #(
    .WIDTH(WIDTH)
  ) u_instr_pc_reg (
    .clk(clk),
    .rst(rst),
    .we (capture),
    .d  (pc_q),
    .q  (instr_pc)
  );

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_unit: directed stimulus, behavioural model, PC register   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fetch_unit;

  localparam int W = 32;
  localparam int M_IDLE = 0;
  localparam int M_FETCH = 1;
  localparam int M_HOLD = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pc_q;
  logic         pc_write;
  logic [W-1:0] pc_next;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack = 1'b0;
  logic [31:0]  imem_rdata = '0;
  logic         redirect = 1'b0;
  logic [W-1:0] redirect_pc = '0;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [W-1:0] instr_pc;
  logic         instr_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_q       (pc_q),
    .pc_write   (pc_write),
    .pc_next    (pc_next),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  // PC register owned by the environment
  always @(posedge clk) begin
    if (rst) pc_q <= '0;
    else if (pc_write) pc_q <= pc_next;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the fetcher has, where it is, and the PC it implies
  int           m_mode;
  logic [W-1:0] m_pc;
  logic [31:0]  m_instr;
  logic [W-1:0] m_ipc;
  logic         m_valid;

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= M_IDLE; m_pc <= '0; m_instr <= '0; m_ipc <= '0; m_valid <= 1'b0;
    end else if (m_mode == M_IDLE) begin
      m_mode <= M_FETCH;
    end else if (redirect) begin
      m_pc <= redirect_pc & ~32'd3; m_valid <= 1'b0; m_mode <= M_FETCH;
    end else if (m_mode == M_FETCH && imem_ack) begin
      m_instr <= imem_rdata; m_ipc <= m_pc; m_pc <= m_pc + 32'd4;
      m_valid <= 1'b1; m_mode <= M_HOLD;
    end else if (m_mode == M_HOLD && instr_ready) begin
      m_valid <= 1'b0; m_mode <= M_FETCH;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_pc_q", pc_q, m_pc);
      chk("m_imem_req", {31'd0, imem_req}, {31'd0, m_mode == M_FETCH});
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      chk("m_instr", instr, m_instr);
      chk("m_instr_pc", instr_pc, m_ipc);
      chk("m_pc_write", {31'd0, pc_write},
          {31'd0, (m_mode != M_IDLE && redirect) ||
                  (m_mode == M_FETCH && imem_ack && !redirect)});
      if (pc_write)
        chk("m_pc_next", pc_next, redirect ? (redirect_pc & ~32'd3) : m_pc + 32'd4);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int pulses;
  int nvalid;

  initial begin
    rst = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    // cycle 1: IDLE
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    tick();
    // cycle 2: first request
    chk("c2_req", {31'd0, imem_req}, 32'd1);
    chk("c2_addr", imem_addr, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013; instr_ready = 1'b1;
    settle();
    chk("c2_pc_write", {31'd0, pc_write}, 32'd1);
    chk("c2_pc_next", pc_next, 32'd4);
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    chk("c3_valid", {31'd0, instr_valid}, 32'd1);
    chk("c3_instr", instr, 32'h0000_0013);
    chk("c3_instr_pc", instr_pc, 32'd0);
    chk("c3_pc_q", pc_q, 32'd4);

    // three wait states before the ack
    instr_ready = 1'b0;
    do_reset();
    tick();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'd0);
      pulses += int'(pc_write);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    settle();
    pulses += int'(pc_write);
    tick();
    imem_ack = 1'b0;
    settle();
    pulses += int'(pc_write);
    chk("wait_pc_write_pulses", pulses, 32'd1);

    // decode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, 32'hDEAD_BEEF);
      chk("stall_instr_pc", instr_pc, 32'd0);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_pc_q", pc_q, 32'd4);
      tick();
    end

    // reset while holding
    do_reset();
    chk("hrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("hrst_instr", instr, 32'd0);
    chk("hrst_req", {31'd0, imem_req}, 32'd0);
    chk("hrst_pc_q", pc_q, 32'd0);
    tick();
    chk("hrst_req2", {31'd0, imem_req}, 32'd1);
    chk("hrst_addr", imem_addr, 32'd0);

    // redirect beats a simultaneous ack
    redirect = 1'b1; redirect_pc = 32'h0000_0102; imem_ack = 1'b1; imem_rdata = 32'h0000_0055;
    settle();
    chk("rd_pc_write", {31'd0, pc_write}, 32'd1);
    chk("rd_pc_next", pc_next, 32'h0000_0100);
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    chk("rd_valid", {31'd0, instr_valid}, 32'd0);
    chk("rd_instr", instr, 32'd0);
    chk("rd_req", {31'd0, imem_req}, 32'd1);
    chk("rd_addr", imem_addr, 32'h0000_0100);

    // top-of-memory fetch wraps the PC
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFD;
    settle();
    chk("wrap_target", pc_next, 32'hFFFF_FFFC);
    tick();
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0011;
    settle();
    chk("wrap_pc_write", {31'd0, pc_write}, 32'd1);
    chk("wrap_pc_next", pc_next, 32'd0);
    tick();
    imem_ack = 1'b0;
    chk("wrap_valid", {31'd0, instr_valid}, 32'd1);
    chk("wrap_instr", instr, 32'h0000_0011);
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_q", pc_q, 32'd0);

    // redirect while holding
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    settle();
    chk("hrd_pc_write", {31'd0, pc_write}, 32'd1);
    chk("hrd_pc_next", pc_next, 32'h0000_0040);
    tick();
    redirect = 1'b0;
    chk("hrd_valid", {31'd0, instr_valid}, 32'd0);
    chk("hrd_addr", imem_addr, 32'h0000_0040);

    // redirect in IDLE is ignored
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h0000_0080;
    settle();
    chk("idle_rd_pc_write", {31'd0, pc_write}, 32'd0);
    tick();
    redirect = 1'b0;
    chk("idle_rd_addr", imem_addr, 32'd0);

    // zero-wait memory, decode always ready
    instr_ready = 1'b1; imem_ack = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      imem_rdata = 32'h0000_1000 + 32'(i);
      tick();
      nvalid += int'(instr_valid);
    end
    chk("tput_valid_cycles", nvalid, 32'd4);
    chk("tput_pc_q", pc_q, 32'd16);
    imem_ack = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch controller that owns the write enable and next value of the PC register. Reads the current PC from the PC register, issues a req/ack request to instruction memory, and holds the fetched word for decode under a valid/ready handshake. Advances the PC by 4 after each completed fetch, or loads a redirect target on branches and jumps.

## Interface
Parameters:
- WIDTH, 32, PC and address width in bits.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- pc_q  in  WIDTH  current PC; the PC register output, which resets to 0.
- pc_write  out  1  PC register write enable.
- pc_next  out  WIDTH  PC register data_in.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  WIDTH  fetch address; equals pc_q.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word; valid only when imem_ack=1.
- redirect  in  1  taken branch or jump from execute.
- redirect_pc  in  WIDTH  redirect target; bits [1:0] are ignored and treated as 00.
- instr_valid  out  1  instr and instr_pc are valid for decode.
- instr  out  32  held instruction word.
- instr_pc  out  WIDTH  address of the held instruction.
- instr_ready  in  1  decode accepts the instruction this cycle.

## Operation
FSM states are IDLE, REQ and HOLD.
- IDLE: entered on reset. Moves to REQ on the next cycle. Drives no request.
- REQ: imem_req=1 and imem_addr=pc_q.
  - On imem_ack: capture imem_rdata into instr and pc_q into instr_pc, set instr_valid, assert pc_write with pc_next=pc_q+4, then go to HOLD.
  - Without imem_ack: stay in REQ with the request held.
- HOLD: instr_valid=1 and imem_req=0.
  - On instr_ready: clear instr_valid and go to REQ.
  - Otherwise: hold all outputs stable.
- Redirect, in any state other than IDLE:
  - Assert pc_write with pc_next={redirect_pc[WIDTH-1:2],2'b00} in that cycle.
  - Clear instr_valid and go to REQ.
  - Redirect has priority over imem_ack and instr_ready; an ack arriving in the same cycle is discarded.
  - If a request is outstanding, it is abandoned. Memory must tolerate imem_addr changing while imem_req stays high.
- Redirect while in IDLE is ignored.
- pc_q+4 wraps modulo 2^WIDTH; no overflow flag is produced.
- pc_write is 0 in every cycle not listed above.
- When pc_write=0, pc_next drives pc_q+4. Its value is don't-care.

## Timing
- Reset values: state=IDLE, pc_write=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0. pc_next is combinational.
- First request is issued in the second cycle after rst deasserts: IDLE, then REQ.
- instr_valid rises in the cycle after the ack cycle. In that same cycle pc_q already shows the incremented PC.
- Zero-wait memory with instr_ready tied high gives one instruction every 2 cycles.
- A redirect in cycle N puts the target on imem_addr in cycle N+1.
- rst mid-fetch returns to IDLE on the next edge and drops any captured instruction. The PC register resets in the same cycle.
- pc_write and pc_next are combinational from state, imem_ack and redirect, so the PC updates on the same edge as the capture.

## Structure
- Package fetch_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {IDLE, REQ, HOLD};
  - localparam INSTR_BYTES = 4.
- The instr and instr_pc holding registers are two instances of the existing register module. Their write input is the capture condition (REQ and imem_ack and not redirect).
- The FSM and next-PC logic live in fetch_unit itself. No other sub-module is used.

## Test plan
- Reset, then memory acks on the first REQ cycle with rdata=0x00000013, instr_ready=1:
  - imem_addr=0 in cycle 2.
  - instr_valid=1 with instr=0x00000013 and instr_pc=0 in cycle 3.
  - pc_q=4 in cycle 3.
- Memory acks after 3 wait cycles: imem_req and imem_addr=0 stay stable for 3 cycles, and pc_write pulses exactly once.
- instr_ready=0 for 5 cycles in HOLD:
  - instr, instr_pc and instr_valid stay constant.
  - No new request is issued.
  - pc_q stays 4.
- Redirect to 0x00000102 while in REQ with a simultaneous ack:
  - The acked data is discarded.
  - pc_next=0x00000100 and instr_valid stays 0.
  - The next imem_addr is 0x00000100.
- pc_q=0xFFFFFFFC with ack: pc_next=0x00000000 (wrap).
- rst asserted during HOLD: next cycle instr_valid=0 and instr=0, then IDLE, then REQ at address 0.
